// File: rtl/psec5_ctmp_readout.sv
// Per-channel CTMP readout: on a synchronized INST_READOUT rising edge, snapshots the
// 56-bit counter word and shifts a 76-bit framed packet out MSB-first on SDO.
module psec5_ctmp_readout #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        SPI_CLK,
    input  logic        RST,
    input  logic        INST_READOUT,
    input  logic [55:0] CTMP,
    input  logic [3:0]  CHAN_ID,
    input  logic        SHIFT_EN,
    output logic        SDO,
    output logic        SDO_FRAME,
    output logic        READOUT_BUSY,
    output logic        READOUT_DONE,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [6:0] LAST_BIT = 7'd75;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   req;
    logic [75:0]            shreg;
    logic [6:0]             count;
    logic [7:0]             cksum;

    // Edge detect runs in every state, so a request arriving while busy is
    // consumed (dropped) rather than deferred until IDLE.
    assign req = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_comb begin
        cksum = 8'h00;
        for (int i = 0; i < 7; i++) begin
            cksum = cksum ^ CTMP[i*8 +: 8];
        end
    end

    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INST_READOUT};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Handshake: while SDO_FRAME is high, SDO carries one frame bit; the bit is
    // consumed on a clock edge where SHIFT_EN=1, otherwise it is held unchanged.
    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) state <= LOAD;
                end
                LOAD: begin
                    shreg <= {HEADER, CHAN_ID, CTMP, cksum};
                    count <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (SHIFT_EN) begin
                        shreg <= {shreg[74:0], 1'b0};
                        if (count == LAST_BIT) begin
                            count <= '0;
                            state <= DONE;
                        end else begin
                            count <= count + 7'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign SDO          = (state == SHIFT) ? shreg[75] : 1'b0;
    assign SDO_FRAME    = (state == SHIFT);
    assign READOUT_BUSY = (state == LOAD) || (state == SHIFT);
    assign READOUT_DONE = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_psec5_ctmp_readout.sv
// Directed bench for psec5_ctmp_readout: frame content, latency, stall, retrigger,
// snapshot and mid-frame reset, each checked against hand-computed frames.
module tb_psec5_ctmp_readout;

    logic        SPI_CLK;
    logic        RST;
    logic        INST_READOUT;
    logic [55:0] CTMP;
    logic [3:0]  CHAN_ID;
    logic        SHIFT_EN;
    logic        SDO;
    logic        SDO_FRAME;
    logic        READOUT_BUSY;
    logic        READOUT_DONE;
    logic [1:0]  fsm_state;

    int n_cmp;
    int n_bad;

    // Observations filled in by run_frame
    logic [75:0] obs_bits;
    int          obs_nbits;
    int          obs_frame_cycles;
    int          obs_first_edge;
    logic [1:0]  obs_load;
    logic        obs_done_after;
    logic        obs_done_next;
    int          obs_stall_ones;
    logic [3:0]  obs_rst_outs;
    logic        obs_rst_next;
    logic        obs_timeout;

    // Hand-computed frames: A5 | chan | CTMP | XOR of CTMP bytes
    localparam logic [75:0] FRAME_A = {8'hA5, 4'h3, 56'h01_2345_6789_ABCD, 8'hEF};
    localparam logic [75:0] FRAME_B = {8'hA5, 4'hC, 56'h80_0000_0000_0001, 8'h81};

    psec5_ctmp_readout dut (
        .SPI_CLK      (SPI_CLK),
        .RST          (RST),
        .INST_READOUT (INST_READOUT),
        .CTMP         (CTMP),
        .CHAN_ID      (CHAN_ID),
        .SHIFT_EN     (SHIFT_EN),
        .SDO          (SDO),
        .SDO_FRAME    (SDO_FRAME),
        .READOUT_BUSY (READOUT_BUSY),
        .READOUT_DONE (READOUT_DONE),
        .fsm_state    (fsm_state)
    );

    initial begin
        SPI_CLK = 1'b0;
        forever #5 SPI_CLK = ~SPI_CLK;
    end

    // Requests a frame and records it. Knobs are -1 when unused; pre_en is the
    // SHIFT_EN level before the first frame bit appears.
    task automatic run_frame(input int pulse_len, input logic pre_en, input int stall_at,
                             input int stall_len, input int retrig_at, input int snap_at,
                             input int rst_at);
        int   pulse_left;
        int   stall_left;
        bit   seen;
        bit   finished;
        obs_bits = '0; obs_nbits = 0; obs_frame_cycles = 0; obs_first_edge = -1;
        obs_load = 2'b00; obs_done_after = 1'b0; obs_done_next = 1'b1;
        obs_stall_ones = 0; obs_rst_outs = 4'hF; obs_rst_next = 1'b1; obs_timeout = 1'b0;
        pulse_left = pulse_len; stall_left = stall_len; seen = 0; finished = 0;
        @(negedge SPI_CLK);
        INST_READOUT = 1'b1;
        SHIFT_EN = pre_en;
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge SPI_CLK);
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) INST_READOUT = 1'b0;
            end
            if (cyc == 3) obs_load = {READOUT_BUSY, SDO_FRAME};
            if (SDO_FRAME) begin
                if (!seen) obs_first_edge = cyc;
                seen = 1;
                obs_frame_cycles++;
                if (obs_nbits == rst_at) begin
                    RST = 1'b1;
                    #1;
                    obs_rst_outs = {SDO, SDO_FRAME, READOUT_BUSY, READOUT_DONE};
                    @(negedge SPI_CLK);
                    RST = 1'b0;
                    @(negedge SPI_CLK);
                    obs_rst_next = READOUT_DONE | SDO_FRAME | READOUT_BUSY;
                    finished = 1;
                end else begin
                    if (obs_nbits == snap_at) CTMP = '1;
                    if (obs_nbits == retrig_at) INST_READOUT = 1'b1;
                    if (obs_nbits == stall_at && stall_left > 0) begin
                        SHIFT_EN = 1'b0;
                        stall_left--;
                        if (SDO === 1'b1) obs_stall_ones++;
                    end else begin
                        SHIFT_EN = 1'b1;
                        obs_bits[75 - obs_nbits] = SDO;
                        obs_nbits++;
                    end
                end
            end else if (seen) begin
                obs_done_after = READOUT_DONE;
                @(negedge SPI_CLK);
                obs_done_next = READOUT_DONE;
                finished = 1;
            end
        end
        if (!finished) obs_timeout = 1'b1;
        SHIFT_EN = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1; INST_READOUT = 1'b0; SHIFT_EN = 1'b1;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        #1;
        n_cmp++;
        if ({SDO, SDO_FRAME, READOUT_BUSY, READOUT_DONE} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 0000", {SDO, SDO_FRAME, READOUT_BUSY, READOUT_DONE});
        end
        n_cmp++;
        if (fsm_state !== 2'd0) begin
            n_bad++; $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        repeat (3) @(negedge SPI_CLK);
        RST = 1'b0;
        repeat (3) @(negedge SPI_CLK);
        n_cmp++;
        if ({SDO_FRAME, READOUT_BUSY} !== 2'b00) begin
            n_bad++; $display("FAIL idle_quiet: got %b want 00", {SDO_FRAME, READOUT_BUSY});
        end
    endtask

    task automatic test_frame;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        run_frame(3, 1'b1, -1, 0, -1, -1, -1);
        n_cmp++;
        if (obs_timeout !== 1'b0) begin n_bad++; $display("FAIL frame_timeout: got %b want 0", obs_timeout); end
        n_cmp++;
        if (obs_load !== 2'b10) begin n_bad++; $display("FAIL frame_load_busy: got %b want 10", obs_load); end
        n_cmp++;
        if (obs_first_edge != 4) begin n_bad++; $display("FAIL frame_latency: got %0d want 4", obs_first_edge); end
        n_cmp++;
        if (obs_frame_cycles != 76) begin n_bad++; $display("FAIL frame_len: got %0d want 76", obs_frame_cycles); end
        n_cmp++;
        if (obs_bits !== FRAME_A) begin n_bad++; $display("FAIL frame_bits: got %h want %h", obs_bits, FRAME_A); end
        n_cmp++;
        if (obs_done_after !== 1'b1) begin n_bad++; $display("FAIL frame_done: got %b want 1", obs_done_after); end
        n_cmp++;
        if (obs_done_next !== 1'b0) begin n_bad++; $display("FAIL frame_done_width: got %b want 0", obs_done_next); end
    endtask

    task automatic test_stall;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        repeat (4) @(negedge SPI_CLK);
        run_frame(3, 1'b0, 20, 10, -1, -1, -1);
        n_cmp++;
        if (obs_first_edge != 4) begin n_bad++; $display("FAIL stall_latency: got %0d want 4", obs_first_edge); end
        n_cmp++;
        if (obs_frame_cycles != 86) begin n_bad++; $display("FAIL stall_len: got %0d want 86", obs_frame_cycles); end
        n_cmp++;
        if (obs_stall_ones != (FRAME_A[55] ? 10 : 0)) begin
            n_bad++; $display("FAIL stall_hold: got %0d ones want %0d", obs_stall_ones, FRAME_A[55] ? 10 : 0);
        end
        n_cmp++;
        if (obs_bits !== FRAME_A) begin n_bad++; $display("FAIL stall_bits: got %h want %h", obs_bits, FRAME_A); end
        n_cmp++;
        if (obs_done_after !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", obs_done_after); end
    endtask

    task automatic test_retrigger;
        int extra;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        repeat (4) @(negedge SPI_CLK);
        run_frame(3, 1'b1, -1, 0, 30, -1, -1);
        n_cmp++;
        if (obs_bits !== FRAME_A) begin n_bad++; $display("FAIL retrig_bits: got %h want %h", obs_bits, FRAME_A); end
        extra = 0;
        repeat (20) begin
            @(negedge SPI_CLK);
            if (SDO_FRAME || READOUT_BUSY) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL retrig_extra: got %0d busy cycles want 0", extra); end
        INST_READOUT = 1'b0;
        repeat (5) @(negedge SPI_CLK);
        run_frame(3, 1'b1, -1, 0, -1, -1, -1);
        n_cmp++;
        if (obs_frame_cycles != 76 || obs_bits !== FRAME_A) begin
            n_bad++; $display("FAIL retrig_second: got %0d cycles %h want 76 %h", obs_frame_cycles, obs_bits, FRAME_A);
        end
    endtask

    task automatic test_snapshot;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        repeat (4) @(negedge SPI_CLK);
        run_frame(3, 1'b1, -1, 0, -1, 10, -1);
        n_cmp++;
        if (obs_bits !== FRAME_A) begin n_bad++; $display("FAIL snapshot_bits: got %h want %h", obs_bits, FRAME_A); end
    endtask

    task automatic test_mid_reset;
        CTMP = 56'h01_2345_6789_ABCD; CHAN_ID = 4'h3;
        repeat (4) @(negedge SPI_CLK);
        run_frame(3, 1'b1, -1, 0, -1, -1, 40);
        n_cmp++;
        if (obs_rst_outs !== 4'b0000) begin n_bad++; $display("FAIL midrst_outs: got %b want 0000", obs_rst_outs); end
        n_cmp++;
        if (obs_rst_next !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got %b want 0", obs_rst_next); end
        repeat (3) @(negedge SPI_CLK);
        run_frame(3, 1'b1, -1, 0, -1, -1, -1);
        n_cmp++;
        if (obs_frame_cycles != 76 || obs_bits !== FRAME_A) begin
            n_bad++; $display("FAIL midrst_next: got %0d cycles %h want 76 %h", obs_frame_cycles, obs_bits, FRAME_A);
        end
    endtask

    task automatic test_back_to_back;
        CTMP = 56'h80_0000_0000_0001; CHAN_ID = 4'hC;
        run_frame(3, 1'b1, -1, 0, -1, -1, -1);
        n_cmp++;
        if (obs_bits !== FRAME_B) begin n_bad++; $display("FAIL b2b_bits: got %h want %h", obs_bits, FRAME_B); end
        n_cmp++;
        if (obs_first_edge != 4 || obs_frame_cycles != 76) begin
            n_bad++; $display("FAIL b2b_timing: got %0d/%0d want 4/76", obs_first_edge, obs_frame_cycles);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_frame();
        test_stall();
        test_retrigger();
        test_snapshot();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
